// File: rtl/tt_check_pkg.sv
// Shared definitions for the truth-table sweep checker: state encoding and
// the default expected-response table for the f5 exercise (s = ~a & b).
package tt_check_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_SAMPLE = ST_SAMPLE,
    S_DONE   = ST_DONE
  } state_t;

  // Bit i is the expected output for stim == i, stim = {a,b}.
  localparam logic [3:0] F5_EXPECT = 4'b0010;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: counts cycles while enabled and flags the terminal count
// SETTLE-1. A clear forces the count back to zero.
module tt_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(SETTLE - 1));

  // Next count: clear wins, otherwise count up and hold at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Truth-table sweep checker: drives every input vector onto stim, waits
// SETTLE cycles, samples two implementations and compares each against
// EXPECT. Reports pass/fail, mismatch count and first failing vector.
// Optional build macro TT_STOP_ON_FAIL_EN: end the sweep at the first
// mismatching vector instead of completing it.
// Handshake: start is a level sampled only in IDLE or DONE; done stays high
// (with results stable) until the next accepted start.
module tt_sweep_checker
  import tt_check_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = F5_EXPECT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp_a,
  input  logic            resp_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            err_a,
  output logic            err_b,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid,
  output logic [1:0]      state_dbg
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic              ea_q, ea_d, eb_q, eb_d;
  logic [N_IN-1:0]   fvec_q, fvec_d;
  logic              fval_q, fval_d;
  logic              settle_tc;
  logic              exp_bit, mis_a, mis_b, stop;

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst   (reset),
    .clr_i (state_q != S_SETTLE),
    .en_i  (state_q == S_SETTLE),
    .tc_o  (settle_tc)
  );

  assign exp_bit = EXPECT[stim_q];
  assign mis_a   = (resp_a != exp_bit);
  assign mis_b   = (resp_b != exp_bit);

  // Next-state, sweep counter and error bookkeeping.
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    fvec_d  = fvec_q;
    fval_d  = fval_q;
    stop    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          stim_d  = '0;
          cnt_d   = '0;
          ea_d    = 1'b0;
          eb_d    = 1'b0;
          fvec_d  = '0;
          fval_d  = 1'b0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_tc) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (mis_a || mis_b) begin
          cnt_d = cnt_q + 1'b1;
          ea_d  = ea_q | mis_a;
          eb_d  = eb_q | mis_b;
          if (!fval_q) begin
            fvec_d = stim_q;
            fval_d = 1'b1;
          end
        end
        stop = (stim_q == LAST_VEC);
`ifdef TT_STOP_ON_FAIL_EN
        stop = stop | mis_a | mis_b;
`endif
        if (stop) begin
          state_d = S_DONE;
        end else begin
          stim_d  = stim_q + 1'b1;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      ea_q    <= 1'b0;
      eb_q    <= 1'b0;
      fvec_q  <= '0;
      fval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      fvec_q  <= fvec_d;
      fval_q  <= fval_d;
    end
  end

  assign stim            = stim_q;
  assign busy            = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (cnt_q == '0);
  assign err_count       = cnt_q;
  assign err_a           = ea_q;
  assign err_b           = eb_q;
  assign first_err_vec   = fvec_q;
  assign first_err_valid = fval_q;
  assign state_dbg       = state_q;

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Synchronous driver and checker for small combinational blocks in the gate-level exercise set. It sits on the input side of the function under test.
- Steps through every input combination and drives it onto `stim`. After a settle delay it samples two implementations of the same function, `resp_a` (gate form) and `resp_b` (expression form), and compares each against a truth-table parameter.
- Reports pass/fail, a mismatch count and the first failing vector. It replaces hand-written `$monitor` sweeps with a synthesizable self-check.

Parameters:
- N_IN, 2, number of function inputs; sweep covers 2**N_IN vectors.
- SETTLE, 1, cycles `stim` is held before sampling; legal range >= 1.
- EXPECT, 4'b0010, expected output per vector; bit i is the expected result for stim == i. Width is 2**N_IN. The default encodes s = ~a & b with stim = {a,b}.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, starts a sweep; sampled only in IDLE or DONE.
- stim, output, N_IN, vector driven to both implementations.
- resp_a, input, 1, output of implementation A.
- resp_b, input, 1, output of implementation B.
- busy, output, 1, high during SETTLE/SAMPLE.
- done, output, 1, high while in DONE.
- pass, output, 1, valid while done; 1 iff err_count == 0.
- err_count, output, N_IN+1, number of vectors with any mismatch.
- err_a, output, 1, sticky; A mismatched at least once.
- err_b, output, 1, sticky; B mismatched at least once.
- first_err_vec, output, N_IN, stim value of the first mismatch; valid when first_err_valid.
- first_err_valid, output, 1, sticky.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - stim = 0, busy = 0, done = 0, pass = 0, err_count = 0.
  - err_a = 0, err_b = 0, first_err_vec = 0, first_err_valid = 0.
  - Reset asserted mid-sweep aborts immediately to these values.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start = 1 → stim <= 0, settle counter <= 0, all error/result registers cleared, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - Counter increments each cycle.
  - When counter == SETTLE-1, go to SAMPLE. This holds stim exactly SETTLE cycles before the sample edge.
- SAMPLE (one cycle):
  - exp = EXPECT[stim]; mA = resp_a != exp; mB = resp_b != exp.
  - If mA | mB: err_count++; err_a |= mA; err_b |= mB.
  - If first_err_valid == 0, latch first_err_vec = stim and set first_err_valid.
  - If stim == 2**N_IN-1, go to DONE. Otherwise stim <= stim+1, counter <= 0, go to SETTLE.
  - The last vector's stim stays at all-ones; no wrap to 0 is driven.
- DONE:
  - done = 1, busy = 0, pass = (err_count == 0).
  - Results hold until start = 1, which behaves exactly as start from IDLE (clear, restart).
- start while busy is ignored; the sweep is not restarted.
- Latency from the start edge to done rising is 2**N_IN*(SETTLE+1) cycles. With default parameters this is 8.
- err_count cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- resp_a and resp_b are sampled directly; no synchronizer. Both are assumed combinational functions of stim.

Optional Feature:
- Macro: TT_STOP_ON_FAIL_EN.
- Defined: a SAMPLE cycle with any mismatch goes directly to DONE after updating the error registers. err_count is then at most 1 and stim holds the failing vector.
- Undefined: the full sweep always completes as described above.

Decomposition:
- Package tt_check_pkg holds:
  - state encoding localparams ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE (2-bit);
  - the default EXPECT constant for the f5 exercise.
- One natural sub-module, tt_settle_timer: a counter with clear input and a terminal-count output at SETTLE-1, parameterized by SETTLE.
- FSM, sweep counter and error bookkeeping stay in the top module.

Test Plan:
- Both responses are the correct s = ~a & b (defaults), start pulsed once:
  - stim sequence 00, 01, 10, 11, each held 1 cycle;
  - done rises 8 cycles after the start edge;
  - pass = 1, err_count = 0.
- resp_a correct, resp_b = a & b:
  - mismatches at 01 and 11;
  - err_count = 2, err_a = 0, err_b = 1;
  - first_err_vec = 01, pass = 0.
- SETTLE = 3, both responses correct:
  - each stim held 3 cycles before its sample;
  - done 16 cycles after start.
- Reset asserted while stim = 10 mid-sweep:
  - all outputs return to reset values asynchronously;
  - a later start runs a clean sweep from 00.
- start pulsed during SETTLE of vector 01: ignored, sweep continues to 10. start pulsed in DONE: results cleared, new sweep from 00.
- TT_STOP_ON_FAIL_EN defined, resp_b = a & b:
  - DONE entered right after sampling 01;
  - err_count = 1, stim = 01, pass = 0.
